// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage and its neighbours (next_pc, decoder).
//  - default widths for the program counter, instruction and retire counter
//  - 2-bit FSM state encoding of the fetch/execute sequencer
//  - instruction immediate field widths used by the target calculator
//  - pcsrc codes agreed with next_pc
package pc_fetch_pkg;

  localparam int unsigned PcWDefault  = 8;
  localparam int unsigned IrWDefault  = 8;
  localparam int unsigned CntWDefault = 16;

  // Immediate fields sit in the low bits of the instruction word.
  localparam int unsigned Imm4W = 4;  // BRZI offset, instr[3:0]
  localparam int unsigned Imm6W = 6;  // JI offset,   instr[5:0]

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StExec  = 2'b10,
    StHalt  = 2'b11
  } fetch_state_e;

  typedef enum logic [2:0] {
    PcSrcBrzr  = 3'b000,
    PcSrcBrzi  = 3'b100,
    PcSrcJi    = 3'b101,
    PcSrcNoJmp = 3'b110
  } pcsrc_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational candidate-target calculator feeding next_pc.
// Ports:
//  pc_i       current program counter
//  instr_i    instruction register
//  rs_val_i   register-file value (BRZR target)
//  std_pc_o   pc + 1
//  brzi_pc_o  pc + sext(instr[3:0])
//  ji_pc_o    pc + sext(instr[5:0])
//  brzr_pc_o  rs_val passthrough
// All sums wrap modulo 2^PcW.
module pc_target_calc
  import pc_fetch_pkg::*;
#(
  parameter int unsigned PcW = PcWDefault,
  parameter int unsigned IrW = IrWDefault
) (
  input  logic [PcW-1:0] pc_i,
  input  logic [IrW-1:0] instr_i,
  input  logic [PcW-1:0] rs_val_i,
  output logic [PcW-1:0] std_pc_o,
  output logic [PcW-1:0] brzi_pc_o,
  output logic [PcW-1:0] ji_pc_o,
  output logic [PcW-1:0] brzr_pc_o
);

  logic [PcW-1:0] imm4_sext;
  logic [PcW-1:0] imm6_sext;

  assign imm4_sext = {{(PcW - Imm4W){instr_i[Imm4W-1]}}, instr_i[Imm4W-1:0]};
  assign imm6_sext = {{(PcW - Imm6W){instr_i[Imm6W-1]}}, instr_i[Imm6W-1:0]};

  assign std_pc_o  = pc_i + PcW'(1);
  assign brzi_pc_o = pc_i + imm4_sext;
  assign ji_pc_o   = pc_i + imm6_sext;
  assign brzr_pc_o = rs_val_i;

  // Opcode bits above the widest immediate are the decoder's business.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr_i[IrW-1:Imm6W];

endmodule

// File: rtl/pc_fetch.sv
// Program counter / instruction register holder and instruction-fetch sequencer.
// Fetches instr from imem at pc, presents it to the decoder until the control unit
// retires it, then loads the next_pc selection. Sequence: IDLE -> FETCH -> EXEC -> FETCH ...
// with HALT as a sink left only through reset.
// Ports:
//  clk_i, rst_i            clock, synchronous active-high reset
//  imem_req_o/addr_o       fetch request and address, held until imem_ack_i
//  imem_ack_i/rdata_i      fetch completion and fetched instruction
//  instr_o, instr_valid_o  instruction register and its EXEC-state qualifier
//  exec_done_i, halt_i     retire strobe from control, halt sampled with it
//  rs_val_i, new_pc_i      BRZR source and selected next PC
//  std/brzi/ji/brzr_pc_o   candidate targets to next_pc
//  pc_o, retired_o         program counter and retired-instruction count
//  halted_o                high in HALT
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned PcW  = PcWDefault,
  parameter int unsigned IrW  = IrWDefault,
  parameter int unsigned CntW = CntWDefault
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [PcW-1:0]  imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [IrW-1:0]  imem_rdata_i,
  output logic [IrW-1:0]  instr_o,
  output logic            instr_valid_o,
  input  logic            exec_done_i,
  input  logic            halt_i,
  input  logic [PcW-1:0]  rs_val_i,
  input  logic [PcW-1:0]  new_pc_i,
  output logic [PcW-1:0]  std_pc_o,
  output logic [PcW-1:0]  brzi_pc_o,
  output logic [PcW-1:0]  ji_pc_o,
  output logic [PcW-1:0]  brzr_pc_o,
  output logic [PcW-1:0]  pc_o,
  output logic [CntW-1:0] retired_o,
  output logic            halted_o
);

  fetch_state_e    state_q, state_d;
  logic [PcW-1:0]  pc_q, pc_d;
  logic [IrW-1:0]  instr_q, instr_d;
  logic [CntW-1:0] retired_q, retired_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    retired_d     = retired_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    halted_o      = 1'b0;
    unique case (state_q)
      // Dead cycle after reset so a stale ack from before reset cannot land.
      StIdle: state_d = StFetch;
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = StExec;
        end
      end
      StExec: begin
        instr_valid_o = 1'b1;
        if (exec_done_i) begin
          pc_d      = new_pc_i;
          retired_d = retired_q + CntW'(1);
          state_d   = halt_i ? StHalt : StFetch;
        end
      end
      StHalt: halted_o = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  // pc only changes on leaving EXEC, so the address is stable for a whole FETCH.
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_q;
  assign retired_o   = retired_q;

  pc_target_calc #(
    .PcW(PcW),
    .IrW(IrW)
  ) u_target_calc (
    .pc_i     (pc_q),
    .instr_i  (instr_q),
    .rs_val_i (rs_val_i),
    .std_pc_o (std_pc_o),
    .brzi_pc_o(brzi_pc_o),
    .ji_pc_o  (ji_pc_o),
    .brzr_pc_o(brzr_pc_o)
  );

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        exec_done;
  logic        halt;
  logic [7:0]  rs_val;
  logic [7:0]  new_pc;
  logic [7:0]  std_pc, brzi_pc, ji_pc, brzr_pc, pc;
  logic [15:0] retired;
  logic        halted;

  pcsrc_e      pcsrc;
  logic        zero;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  addr_q[$];
  logic [7:0]  cur_pc;
  logic [7:0]  cur_instr;
  logic [15:0] exp_retired;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .instr_o      (instr),
    .instr_valid_o(instr_valid),
    .exec_done_i  (exec_done),
    .halt_i       (halt),
    .rs_val_i     (rs_val),
    .new_pc_i     (new_pc),
    .std_pc_o     (std_pc),
    .brzi_pc_o    (brzi_pc),
    .ji_pc_o      (ji_pc),
    .brzr_pc_o    (brzr_pc),
    .pc_o         (pc),
    .retired_o    (retired),
    .halted_o     (halted)
  );

  // Stand-in for next_pc: pick among the DUT's candidate targets.
  always_comb begin
    new_pc = std_pc;
    case (pcsrc)
      PcSrcBrzr: if (zero) new_pc = brzr_pc;
      PcSrcBrzi: if (zero) new_pc = brzi_pc;
      PcSrcJi:   new_pc = ji_pc;
      default:   new_pc = std_pc;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference next-PC computation using signed integer offsets.
  function automatic logic [7:0] exp_next(input logic [7:0] p, input logic [7:0] ins,
                                          input pcsrc_e src, input logic z,
                                          input logic [7:0] rs);
    int off;
    int sum;
    logic [31:0] s;
    case (src)
      PcSrcBrzr: return z ? rs : p + 8'd1;
      PcSrcBrzi: begin
        off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
        sum = int'(p) + off;
        s   = sum;
        return z ? s[7:0] : p + 8'd1;
      end
      PcSrcJi: begin
        off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        sum = int'(p) + off;
        s   = sum;
        return s[7:0];
      end
      default: return p + 8'd1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
    check("rst_retired", retired, 0);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    addr_q.delete();
    addr_q.push_back(8'd0);
    cur_pc      = 8'd0;
    exp_retired = 16'd0;
    tick();
  endtask

  // imem model: answer after 'delay' wait cycles with 'data'.
  task automatic fetch(input int unsigned delay, input logic [7:0] data);
    logic [7:0] exp_addr;
    if (addr_q.size() == 0) begin
      check("sb_empty", 1, 0);
      exp_addr = cur_pc;
    end else begin
      exp_addr = addr_q.pop_front();
    end
    for (int i = 0; i < int'(delay); i++) begin
      check("req_wait", imem_req, 1);
      check("addr_wait", imem_addr, exp_addr);
      check("valid_wait", instr_valid, 0);
      tick();
    end
    check("req", imem_req, 1);
    check("addr", imem_addr, exp_addr);
    check("valid_fetch", instr_valid, 0);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 8'($urandom);
    check("valid_exec", instr_valid, 1);
    check("req_exec", imem_req, 0);
    check("instr", instr, data);
    cur_pc    = exp_addr;
    cur_instr = data;
  endtask

  task automatic exec(input pcsrc_e src, input logic z, input logic [7:0] rs, input logic h);
    logic [7:0] nxt;
    nxt = exp_next(cur_pc, cur_instr, src, z, rs);
    check("pc_exec", pc, cur_pc);
    pcsrc     = src;
    zero      = z;
    rs_val    = rs;
    halt      = h;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    halt      = 1'b0;
    exp_retired++;
    check("pc_next", pc, nxt);
    check("retired", retired, exp_retired);
    if (!h) addr_q.push_back(nxt);
    cur_pc = nxt;
  endtask

  initial begin
    logic [7:0] a;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0; halt = 1'b0;
    rs_val = '0; pcsrc = PcSrcNoJmp; zero = 1'b0;
    cur_instr = '0;

    // 1: sequential fetch, two cycles per instruction
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fetch(0, 8'(8'h10 + i));
      exec(PcSrcNoJmp, 1'b0, 8'd0, 1'b0);
    end
    check("retired_4", retired, 4);

    // 2: BRZI taken / not taken from pc=5
    fetch(0, 8'h30);
    exec(PcSrcNoJmp, 1'b0, 8'd0, 1'b0);
    fetch(0, 8'h0E);
    check("brzi_m2", brzi_pc, 3);
    exec(PcSrcBrzi, 1'b1, 8'd0, 1'b0);
    fetch(0, 8'h02);
    exec(PcSrcJi, 1'b0, 8'd0, 1'b0);
    fetch(0, 8'h0E);
    exec(PcSrcBrzi, 1'b0, 8'd0, 1'b0);

    // 3: JI wrap, BRZR, std and brzi wrap
    fetch(0, 8'h00);
    exec(PcSrcBrzr, 1'b1, 8'd250, 1'b0);
    fetch(0, 8'h0A);
    check("ji_wrap", ji_pc, 4);
    exec(PcSrcJi, 1'b0, 8'd0, 1'b0);
    fetch(0, 8'h00);
    exec(PcSrcBrzr, 1'b1, 8'd13, 1'b0);
    fetch(0, 8'h00);
    check("brzr_pass", brzr_pc, 8'd13);
    exec(PcSrcBrzr, 1'b1, 8'd255, 1'b0);
    fetch(0, 8'h00);
    check("std_wrap", std_pc, 0);
    exec(PcSrcNoJmp, 1'b0, 8'd0, 1'b0);
    fetch(0, 8'h00);
    exec(PcSrcBrzr, 1'b1, 8'd2, 1'b0);
    fetch(0, 8'h0C);
    check("brzi_wrap", brzi_pc, 254);
    exec(PcSrcBrzi, 1'b1, 8'd0, 1'b0);

    // 4: slow ack, then a spurious ack in EXEC
    fetch(3, 8'h5A);
    imem_ack = 1'b1; imem_rdata = 8'hFF;
    tick();
    imem_ack = 1'b0;
    check("spur_instr", instr, 8'h5A);
    check("spur_valid", instr_valid, 1);
    check("spur_pc", pc, 254);
    exec(PcSrcNoJmp, 1'b0, 8'd0, 1'b0);

    // 5: reset while FETCH is waiting on an ack
    a = addr_q.pop_front();
    check("pre_rst_addr", imem_addr, a);
    check("pre_rst_req", imem_req, 1);
    tick();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 8'hA5;
    tick();
    rst = 1'b0;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_retired", retired, 0);
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", instr_valid, 0);
    tick();
    imem_ack = 1'b0;
    check("idle_ack_instr", instr, 0);
    check("idle_ack_valid", instr_valid, 0);
    addr_q.delete();
    addr_q.push_back(8'd0);
    cur_pc = 8'd0;
    exp_retired = 16'd0;
    fetch(0, 8'h00);
    exec(PcSrcBrzr, 1'b1, 8'd7, 1'b0);

    // 6: halt at pc=7
    fetch(0, 8'h00);
    exec(PcSrcNoJmp, 1'b0, 8'd0, 1'b1);
    check("halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      imem_ack  = 1'($urandom);
      exec_done = 1'($urandom);
      halt      = 1'($urandom);
      tick();
      check("halt_req", imem_req, 0);
      check("halt_flag", halted, 1);
      check("halt_pc", pc, 8);
      check("halt_retired", retired, exp_retired);
    end
    imem_ack = 1'b0; exec_done = 1'b0; halt = 1'b0;
    do_reset();
    check("post_halt_req", imem_req, 1);
    check("post_halt_addr", imem_addr, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
